// File: rtl/display_pkg.sv
// Shared constants and state encoding for the display frame-buffer path.
package display_pkg;

  localparam int LINE_W         = 48;
  localparam int BYTES_PER_LINE = 6;
  localparam int FB_LINES       = 3201;
  localparam int FB_ADDR_W      = 12;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

endpackage

// File: rtl/ram_line_writer_line_packer.sv
// Accumulates bytes of one RAM line and presents the line left-aligned,
// including the byte being loaded this cycle, so a commit can capture it
// in the same cycle as the handshake.
module line_packer
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              last,
  input  logic [7:0]        data_in,
  output logic              full,
  output logic [LINE_W-1:0] word
);

  logic [LINE_W-1:0] sreg;
  logic [LINE_W-1:0] shifted;
  logic [2:0]        cnt;
  logic [5:0]        shamt;

  // Shift the incoming byte in at the bottom, then slide the line up so the
  // oldest byte sits in the top byte lane and unused lanes read as zero.
  always_comb begin
    shifted = {sreg[LINE_W-9:0], data_in};
    full    = (cnt == 3'(BYTES_PER_LINE - 1));
    shamt   = {3'(BYTES_PER_LINE - 1) - cnt, 3'b000};
    word    = shifted << shamt;
  end

  // Byte storage and count; a completed or final byte empties the line.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      if (full || last) begin
        sreg <= '0;
        cnt  <= '0;
      end else begin
        sreg <= shifted;
        cnt  <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ram_line_writer.sv
// Packs the incoming byte stream into 48-bit lines and drives the frame
// buffer RAM write port, one write strobe per committed line.
module ram_line_writer
  import display_pkg::*;
#(
  parameter int NUM_LINES = FB_LINES,
  parameter int ADDR_W    = FB_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  output logic              wr,
  output logic [ADDR_W-1:0] addrWrite,
  output logic [LINE_W-1:0] dataLine,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              commit;
  logic              last_line;
  logic              pk_full;
  logic [LINE_W-1:0] pk_word;
  logic [ADDR_W-1:0] line_addr;

  // A start pulse always wins, so a byte offered alongside it is dropped.
  assign accept    = i_valid && o_ready && !i_start;
  assign commit    = accept && (pk_full || i_last);
  assign last_line = (line_addr == ADDR_W'(NUM_LINES - 1));

  line_packer u_packer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (accept),
    .clear   (i_start),
    .last    (i_last),
    .data_in (i_byte),
    .full    (pk_full),
    .word    (pk_word)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and status decode; a frame ends on i_last or the final line.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_next = RECV;
      end
      RECV: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_start)                             state_next = RECV;
        else if (commit && (i_last || last_line)) state_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) state_next = RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line address, RAM write port registers and the sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      line_addr  <= '0;
      wr         <= 1'b0;
      addrWrite  <= '0;
      dataLine   <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr <= commit;
      if (commit) begin
        addrWrite <= line_addr;
        dataLine  <= pk_word;
        if (!last_line) line_addr <= line_addr + ADDR_W'(1);
      end
      if (i_start) begin
        line_addr  <= '0;
        o_overflow <= 1'b0;
      end else if (state == DONE && i_valid) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_line_writer.sv
// Directed bench for ram_line_writer with a write-port scoreboard and RAM model.
module tb_ram_line_writer;

  localparam int NL = 3201;

  typedef struct packed {
    logic [11:0] addr;
    logic [47:0] data;
    logic        fin;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic        i_last;
  logic        wr;
  logic [11:0] addrWrite;
  logic [47:0] dataLine;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [47:0] ram [0:4095];
  int          wr_count [0:4095];

  logic [11:0] m_addr;
  logic [2:0]  m_cnt;
  logic [47:0] m_word;

  logic [7:0]  rnd_bytes [0:99];
  logic [47:0] gold [0:16];

  ram_line_writer dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_byte     (i_byte),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_last     (i_last),
    .wr         (wr),
    .addrWrite  (addrWrite),
    .dataLine   (dataLine),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference line assembly: bytes placed by position within the line.
  task automatic model_start();
    m_addr = '0;
    m_cnt  = '0;
    m_word = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    m_word[47 - 8*m_cnt -: 8] = b;
    if (m_cnt == 3'd5 || last) begin
      sb.push_back('{addr: m_addr, data: m_word, fin: (last || m_addr == 12'(NL - 1))});
      m_word = '0;
      m_cnt  = '0;
      if (m_addr != 12'(NL - 1)) m_addr = m_addr + 12'd1;
    end else begin
      m_cnt = m_cnt + 3'd1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic last);
    model_byte(b, last);
    i_byte  = b;
    i_last  = last;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    model_start();
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge i_clk);
    #1;
    check_output(tag, 64'(sb.size()), 64'd0);
  endtask

  // Write-port monitor: every strobe must match the next expected line.
  always @(negedge i_clk) begin
    if (wr === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL unexpected_wr got addr=%0h data=%0h exp=no_write", addrWrite, dataLine);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("wr_addr", 64'(addrWrite), 64'(e.addr));
        check_output("wr_data", 64'(dataLine), 64'(e.data));
        check_output("wr_done", 64'(o_done), 64'(e.fin));
      end
      ram[addrWrite]      = dataLine;
      wr_count[addrWrite] = wr_count[addrWrite] + 1;
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_byte  = '0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    model_start();
    for (int i = 0; i < 4096; i++) wr_count[i] = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] reset values");
    check_output("rst_ready", 64'(o_ready), 64'd0);
    check_output("rst_wr", 64'(wr), 64'd0);
    check_output("rst_addr", 64'(addrWrite), 64'd0);
    check_output("rst_data", 64'(dataLine), 64'd0);
    check_output("rst_busy", 64'(o_busy), 64'd0);
    check_output("rst_done", 64'(o_done), 64'd0);
    check_output("rst_ovf", 64'(o_overflow), 64'd0);

    $display("[TB] two full lines");
    pulse_start();
    check_output("t1_ready", 64'(o_ready), 64'd1);
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(8'(i), 1'b0);
      check_output("t1_busy", 64'(o_busy), 64'd1);
    end
    drain("t1_drain");
    check_output("t1_busy_end", 64'(o_busy), 64'd1);

    $display("[TB] partial last line");
    pulse_start();
    for (int i = 0; i < 8; i++) apply_stimulus(8'hA0 + 8'(i), i == 7);
    drain("t2_drain");
    check_output("t2_done", 64'(o_done), 64'd1);
    check_output("t2_busy", 64'(o_busy), 64'd0);

    $display("[TB] full frame");
    pulse_start();
    for (int i = 0; i < NL * 6; i++) apply_stimulus(8'($urandom), 1'b0);
    drain("t3_drain");
    check_output("t3_done", 64'(o_done), 64'd1);
    check_output("t3_last_addr", 64'(addrWrite), 64'(NL - 1));
    check_output("t3_ovf_pre", 64'(o_overflow), 64'd0);
    i_valid = 1'b1;
    i_byte  = 8'h5A;
    #1;
    check_output("t3_ready_done", 64'(o_ready), 64'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check_output("t3_ovf", 64'(o_overflow), 64'd1);
    drain("t3_no_extra_wr");

    $display("[TB] restart discards partial line");
    pulse_start();
    check_output("t4_ovf_clr", 64'(o_overflow), 64'd0);
    check_output("t4_done_clr", 64'(o_done), 64'd0);
    i_byte  = 8'hEE;
    i_valid = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) apply_stimulus(8'h11 + 8'(i), 1'b0);
    drain("t4_drain");

    $display("[TB] random gaps");
    for (int i = 0; i < 4096; i++) wr_count[i] = 0;
    for (int l = 0; l < 17; l++) gold[l] = '0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      rnd_bytes[i] = 8'($urandom);
      gold[i / 6][47 - 8*(i % 6) -: 8] = rnd_bytes[i];
      while ($urandom_range(1, 0) == 1) begin
        @(posedge i_clk); #1;
      end
      apply_stimulus(rnd_bytes[i], i == 99);
    end
    drain("t5_drain");
    for (int l = 0; l < 17; l++) begin
      check_output("t5_ram", 64'(ram[l]), 64'(gold[l]));
      check_output("t5_wr_once", 64'(wr_count[l]), 64'd1);
    end
    check_output("t5_no_wr_17", 64'(wr_count[17]), 64'd0);

    $display("[TB] reset mid-line");
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      i_byte  = 8'h30 + 8'(i);
      i_valid = 1'b1;
      @(posedge i_clk); #1;
    end
    i_byte  = 8'h33;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    check_output("t6_ready", 64'(o_ready), 64'd0);
    check_output("t6_wr", 64'(wr), 64'd0);
    check_output("t6_addr", 64'(addrWrite), 64'd0);
    check_output("t6_data", 64'(dataLine), 64'd0);
    check_output("t6_busy", 64'(o_busy), 64'd0);
    check_output("t6_done", 64'(o_done), 64'd0);
    check_output("t6_ovf", 64'(o_overflow), 64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      check_output("t6_idle_ready", 64'(o_ready), 64'd0);
    end
    i_valid = 1'b0;
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_line_writer.md
# ram_line_writer

Packs a byte stream from the image-transfer path into 48-bit lines and writes them into the image `ram` through its write port (`wr`, `addrWrite`, `dataLine`). It is the producer for the display frame buffer. A frame starts at address 0, advances one line per 6 bytes, and ends on the last byte of the transfer or when the buffer is full. The display side reads the buffer through the RAM read port, which this block never touches.

## Interface
Parameters:
- `NUM_LINES`, default 3201: number of lines in the frame buffer (addresses 0..3200).
- `ADDR_W`, default 12: address width, matching `addrWrite`.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_start`  in  1  one-cycle pulse that begins a new frame at address 0.
- `i_byte`  in  8  payload byte.
- `i_valid`  in  1  `i_byte` is valid.
- `o_ready`  out  1  block accepts a byte this cycle.
- `i_last`  in  1  qualifies the final byte of the transfer; sampled only on a handshake.
- `wr`  out  1  RAM write strobe, one cycle per line.
- `addrWrite`  out  ADDR_W  RAM write address.
- `dataLine`  out  48  RAM write data.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  frame complete; level signal, cleared by `i_start`.
- `o_overflow`  out  1  sticky; a byte was offered while in DONE. Cleared by `i_start`.

## Operation
- Handshake: a byte transfers when `i_valid && o_ready`. Throughput is 1 byte/cycle.
- States:
  - IDLE: `o_ready=0`. `i_start` moves to RECV and clears address, byte count and shift register.
  - RECV: `o_ready=1`, `o_busy=1`.
  - DONE: `o_done=1`, `o_ready=0`. `i_start` moves to RECV.
- Packing: the first byte of a line lands in `dataLine[47:40]` and the sixth byte in `[7:0]`. The byte count runs 0..5.
- Line commit happens on the handshake of the 6th byte, or of any byte with `i_last=1`.
  - Commit registers the packed word, the current address, and `wr=1` for the next cycle.
  - The address then increments and the byte count returns to 0.
- Partial line on `i_last` with k<6 bytes: bytes are left-aligned and the low (6-k)*8 bits are zero.
- End of frame:
  - A commit caused by `i_last` goes to DONE.
  - A commit to address `NUM_LINES-1` goes to DONE even if `i_last` is absent.
- In DONE, `i_valid=1` without `i_start` sets `o_overflow`. The byte is not accepted.
- `i_start` in RECV restarts the frame: the pending partial line is discarded and not written. A commit already registered still completes its `wr` pulse.
- `i_start` and `i_valid` in the same cycle: `i_start` wins. The byte is not accepted because `o_ready` is low that cycle in IDLE/DONE; in RECV, this rule discards the byte.
- Address arithmetic is unsigned ADDR_W; it never exceeds `NUM_LINES-1` and never wraps.

## Timing
- Reset values: state IDLE, `o_ready=0`, `wr=0`, `addrWrite=0`, `dataLine=0`, `o_busy=0`, `o_done=0`, `o_overflow=0`.
- `wr` is high for exactly one cycle, one cycle after the committing handshake.
- `addrWrite` and `dataLine` are valid while `wr=1` and held until the next commit.
- The RAM samples the write on the following `i_clk` edge, so line N is readable 2 cycles after its committing byte.
- `o_done` rises in the same cycle as the final `wr`.
- Back-to-back lines at full rate produce `wr` every 6 cycles with no stall.
- Reset mid-frame: all state clears on the next edge and no `wr` is issued.

## Structure
- Shared package `display_pkg`:
  - `LINE_W=48`, `BYTES_PER_LINE=6`, `FB_LINES=3201`, `FB_ADDR_W=12`.
  - State enum `{IDLE, RECV, DONE}`.
- One sub-module, `line_packer`: a 48-bit shift register with a 3-bit byte counter.
  - Inputs: load, clear, last.
  - Outputs: `full` and a left-aligned word.
- The top level holds the FSM, address counter and output registers.

## Test plan
- Reset, start, then 12 bytes 0x01..0x0C, no `i_last`:
  - `wr` at addr 0 with `0x010203040506`, then at addr 1 with `0x0708090A0B0C`.
  - `o_busy=1` throughout.
- Start, then 8 bytes 0xA0..0xA7 with `i_last` on the 8th:
  - addr 0 gets `0xA0A1A2A3A4A5`; addr 1 gets `0xA6A70000_0000`.
  - `o_done=1` in the same cycle as the second `wr`.
- Full frame of 3201*6 bytes, no `i_last`:
  - last `wr` at addr 3200, then DONE.
  - one extra `i_valid` sets `o_overflow=1` and produces no `wr`.
- Start, 3 bytes, `i_start` pulse, 6 bytes 0x11..0x16:
  - no write for the partial line.
  - addr 0 gets `0x111213141516`.
- Random `i_valid` gaps (~50% duty) over 100 bytes: a RAM model matches the packed golden image, and `wr` is never asserted twice for one address.
- Drop `i_rst_n` on the 4th byte of a line: no `wr`, all outputs return to reset values, and `o_ready=0` until the next `i_start`.
